rv_alu_mc: RTL and testbench

//  Parametrised multi-cycle RV ALU: base RV32I ALU ops plus the M-extension (MUL/MULH*/DIV*/REM*).

---
 rtl/rv_alu_mc_if.sv | 31 +++
 rtl/rv_alu_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_rv_alu_mc.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_alu_mc_if.sv
// -----------------------------------------------------------------------------
// rv_alu_mc_if
// Request/response bundle for the multi-cycle RV ALU.
//   op_in/rs1/rs2/in_valid/flush/out_ready : driven by the issuing stage (master)
//   in_ready/rd/zero/out_valid/busy        : driven by the ALU (slave)
// -----------------------------------------------------------------------------
interface rv_alu_mc_if #(
  parameter int XLEN = 32
) ();
  logic [4:0]      op_in;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [XLEN-1:0] rd;
  logic            zero;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    output op_in, rs1, rs2, in_valid, flush, out_ready,
    input  in_ready, rd, zero, out_valid, busy
  );

  modport slave (
    input  op_in, rs1, rs2, in_valid, flush, out_ready,
    output in_ready, rd, zero, out_valid, busy
  );
endinterface

// File: rtl/rv_alu_mc.sv
// -----------------------------------------------------------------------------
// rv_alu_mc
// Multi-cycle RV32I/RV64I ALU with the M extension. Base ops and the RISC-V
// divide corner cases finish in one cycle; MUL*/DIV*/REM* iterate one bit per
// cycle on operand magnitudes, with the sign applied when the result is stored.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : synchronous active-low reset
//   alu    : rv_alu_mc_if.slave (op/operands/valid in, result/zero/valid out,
//            flush, out_ready, busy, in_ready)
// -----------------------------------------------------------------------------
module rv_alu_mc #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rv_alu_mc_if.slave  alu
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_XOR    = 5'd2,  OP_OR    = 5'd3,
    OP_AND  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL    = 5'd6,  OP_SRA   = 5'd7,
    OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU  = 5'd15,
    OP_REM  = 5'd16, OP_REMU = 5'd17
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Architectural / output registers
  state_e            state_q;
  logic [XLEN-1:0]   rd_q;
  logic              zero_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  // Iterative datapath registers
  logic [4:0]        op_q;
  logic [2*XLEN-1:0] p_q;       // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q;    // mul: multiplicand magnitude; div: divisor magnitude
  logic              neg_q;     // negate product / quotient at the end
  logic              rneg_q;    // negate remainder at the end
  logic [SW-1:0]     cnt_q;

  logic [4:0]        op;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [SW-1:0]     shamt;
  assign op    = alu.op_in;
  assign rs1   = alu.rs1;
  assign rs2   = alu.rs2;
  assign shamt = rs2[SW-1:0];

  // ---------------------------------------------------------------------------
  // Issue-side decode
  // ---------------------------------------------------------------------------
  logic            is_mul, is_div, rs1_signed, rs2_signed;
  logic            a_neg, b_neg, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept;

  assign is_mul     = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_div     = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign rs1_signed = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign rs2_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign a_neg      = rs1_signed & rs1[XLEN-1];
  assign b_neg      = rs2_signed & rs2[XLEN-1];
  assign a_mag      = a_neg ? -rs1 : rs1;
  assign b_mag      = b_neg ? -rs2 : rs2;
  assign div_zero   = is_div && (rs2 == '0);
  // Only signed divide can overflow: -2^(XLEN-1) / -1.
  assign div_ovf    = (op == OP_DIV || op == OP_REM) &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign fast       = div_zero | div_ovf;
  // Flush wins over a simultaneous request.
  assign accept     = alu.in_valid & in_ready_q & ~alu.flush;

  // ---------------------------------------------------------------------------
  // Single-cycle result: base ops, divide corner cases, unused opcodes -> 0
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] one_cycle_res;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    one_cycle_res = '0;
    case (op)
      OP_ADD:  one_cycle_res = rs1 + rs2;
      OP_SUB:  one_cycle_res = rs1 - rs2;
      OP_XOR:  one_cycle_res = rs1 ^ rs2;
      OP_OR:   one_cycle_res = rs1 | rs2;
      OP_AND:  one_cycle_res = rs1 & rs2;
      OP_SLL:  one_cycle_res = rs1 << shamt;
      OP_SRL:  one_cycle_res = rs1 >> shamt;
      OP_SRA:  one_cycle_res = XLEN'($signed(rs1) >>> shamt);
      OP_SLT:  one_cycle_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: one_cycle_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_DIV, OP_DIVU: one_cycle_res = div_zero ? '1  : rs1;
      OP_REM, OP_REMU: one_cycle_res = div_zero ? rs1 : '0;
      default: one_cycle_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step and final sign fix-up
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] p_mul, p_div, p_next, prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    // Shift-add: add multiplicand into the top half when the multiplier LSB is
    // set, then shift the whole {sum, multiplier} pair right by one.
    mul_addend = p_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    p_mul      = {mul_sum, p_q[XLEN-1:1]};

    // Restoring divide: shift {rem, quot} left, try subtracting the divisor,
    // keep the difference and set the quotient bit when it did not borrow.
    div_top    = p_q[2*XLEN-1:XLEN-1];
    div_diff   = div_top - {1'b0, opnd_q};
    if (!div_diff[XLEN]) p_div = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    else                 p_div = {p_q[2*XLEN-2:0], 1'b0};

    p_next = (op_q >= OP_DIV) ? p_div : p_mul;

    prod = neg_q  ? -p_next : p_next;
    quot = neg_q  ? -p_next[XLEN-1:0]      : p_next[XLEN-1:0];
    rem  = rneg_q ? -p_next[2*XLEN-1:XLEN] : p_next[2*XLEN-1:XLEN];

    calc_res = '0;
    case (op_q)
      OP_MUL:                      calc_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             calc_res = quot;
      OP_REM, OP_REMU:             calc_res = rem;
      default:                     calc_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      // NOTE: the iterative datapath is reset as well so simulation never
      // carries X from it into rd, even though IDLE reloads it before use.
      op_q        <= '0;
      p_q         <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            zero_q     <= (rs1 == rs2);
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            if ((is_mul || is_div) && !fast) begin
              state_q <= S_CALC;
              op_q    <= op;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              cnt_q   <= '0;
              if (is_mul) begin
                p_q    <= {{XLEN{1'b0}}, b_mag};
                opnd_q <= a_mag;
              end else begin
                p_q    <= {{XLEN{1'b0}}, a_mag};
                opnd_q <= b_mag;
              end
            end else begin
              state_q     <= S_DONE;
              rd_q        <= one_cycle_res;
              out_valid_q <= 1'b1;
            end
          end
        end

        S_CALC: begin
          if (alu.flush) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            p_q   <= p_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SW'(XLEN-1)) begin
              state_q     <= S_DONE;
              rd_q        <= calc_res;
              out_valid_q <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (alu.flush || alu.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign alu.rd        = rd_q;
  assign alu.zero      = zero_q;
  assign alu.out_valid = out_valid_q;
  assign alu.in_ready  = in_ready_q;
  assign alu.busy      = busy_q;

endmodule

// File: tb/tb_rv_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_rv_alu_mc
// Self-checking bench for rv_alu_mc (XLEN = 32): directed vector table,
// hand-written handshake/flush/reset sequences, and random ops compared with a
// plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_rv_alu_mc;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rv_alu_mc_if #(.XLEN(XLEN)) alu ();

  rv_alu_mc #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: RISC-V semantics via 64-bit arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_rd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa  = $signed(a);
    longint          sb  = $signed(b);
    longint unsigned ua  = a;
    longint unsigned ub  = b;
    logic [63:0]     t;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a ^ b;
      5'd3:  return a | b;
      5'd4:  return a & b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: begin t = sa * sb; return t[31:0];  end
      5'd11: begin t = sa * sb; return t[63:32]; end
      5'd12: begin t = sa * longint'(ub); return t[63:32]; end
      5'd13: begin t = ua * ub; return t[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        t = sa / sb; return t[31:0];
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        t = sa % sb; return t[31:0];
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op >= 5'd10 && op <= 5'd13) return XLEN + 1;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0) return 1;
      if ((op == 5'd14 || op == 5'd16) && ovf) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // ---------------------------------------------------------------------------
  // One full transaction with out_ready held high. Called at posedge+1.
  // lat = index of the first cycle after the accept edge with out_valid high.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rd_o, output logic z_o, output int lat);
    int guard = 0;
    rd_o = '0;
    z_o  = 1'b0;
    lat  = 0;
    while (!alu.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!alu.in_ready) begin
      check("in_ready_wait", alu.in_ready, 1);
      return;
    end
    alu.op_in    = op;
    alu.rs1      = a;
    alu.rs2      = b;
    alu.in_valid = 1'b1;
    @(posedge clk); #1;
    alu.in_valid = 1'b0;
    lat = 1;
    while (!alu.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    rd_o = alu.rd;
    z_o  = alu.zero;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        z;
    int          lat;
  } vec_t;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    logic        z;
    int          lat;
    logic        seen;

    alu.op_in     = '0;
    alu.rs1       = '0;
    alu.rs2       = '0;
    alu.in_valid  = 1'b0;
    alu.flush     = 1'b0;
    alu.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst_rd",        alu.rd,        0);
    check("rst_zero",      alu.zero,      0);
    check("rst_out_valid", alu.out_valid, 0);
    check("rst_busy",      alu.busy,      0);
    check("rst_in_ready",  alu.in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: {op, rs1, rs2, rd, zero, latency}
    vecs.push_back('{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1});
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33});
    vecs.push_back('{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 33});
    vecs.push_back('{5'd10, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33});
    vecs.push_back('{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{5'd15, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd17, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1});
    vecs.push_back('{5'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33});
    vecs.push_back('{5'd8,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1});
    vecs.push_back('{5'd9,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{5'd5,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1});
    vecs.push_back('{5'd2,  32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1});
    vecs.push_back('{5'd3,  32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1});
    vecs.push_back('{5'd4,  32'hF000_000F, 32'h3000_0003, 32'h3000_0003, 1'b0, 1});
    vecs.push_back('{5'd20, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1});

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      check($sformatf("vec%0d_rd", i),   r,   vecs[i].rd);
      check($sformatf("vec%0d_zero", i), z,   vecs[i].z);
      check($sformatf("vec%0d_lat", i),  lat, vecs[i].lat);
    end

    // Result held while out_ready is low; no new issue until the handshake
    alu.out_ready = 1'b0;
    alu.op_in = 5'd14; alu.rs1 = 32'd100; alu.rs2 = 32'd7; alu.in_valid = 1'b1;
    @(posedge clk); #1;
    alu.in_valid = 1'b0;
    lat = 1;
    while (!alu.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("hold_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d_out_valid", i), alu.out_valid, 1);
      check($sformatf("hold%0d_rd", i),        alu.rd,        32'd14);
      check($sformatf("hold%0d_in_ready", i),  alu.in_ready,  0);
      @(posedge clk); #1;
    end
    alu.out_ready = 1'b1;
    check("hold_release_in_ready_same", alu.in_ready, 0);
    @(posedge clk); #1;
    check("hold_release_in_ready", alu.in_ready,  1);
    check("hold_release_out_valid", alu.out_valid, 0);

    // Flush in CALC cycle 5
    alu.op_in = 5'd10; alu.rs1 = 32'd3; alu.rs2 = 32'd5; alu.in_valid = 1'b1;
    @(posedge clk); #1;
    alu.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("flush_pre_busy", alu.busy, 1);
    alu.flush = 1'b1;
    @(posedge clk); #1;
    alu.flush = 1'b0;
    check("flush_busy",      alu.busy,      0);
    check("flush_in_ready",  alu.in_ready,  1);
    check("flush_out_valid", alu.out_valid, 0);
    check("flush_rd_kept",   alu.rd,        32'd14);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (alu.out_valid) seen = 1'b1; end
    check("flush_no_result", seen, 0);
    do_op(5'd0, 32'd2, 32'd3, r, z, lat);
    check("post_flush_add_rd",  r,   32'd5);
    check("post_flush_add_lat", lat, 1);

    // Flush in IDLE beats a simultaneous request
    alu.op_in = 5'd0; alu.rs1 = 32'd9; alu.rs2 = 32'd9; alu.in_valid = 1'b1; alu.flush = 1'b1;
    @(posedge clk); #1;
    alu.in_valid = 1'b0; alu.flush = 1'b0;
    check("idle_flush_busy",      alu.busy,      0);
    check("idle_flush_out_valid", alu.out_valid, 0);
    check("idle_flush_rd",        alu.rd,        32'd5);

    // Reset in the middle of a multiply
    alu.op_in = 5'd10; alu.rs1 = 32'd6; alu.rs2 = 32'd6; alu.in_valid = 1'b1;
    @(posedge clk); #1;
    alu.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_rd",        alu.rd,        0);
    check("midrst_zero",      alu.zero,      0);
    check("midrst_out_valid", alu.out_valid, 0);
    check("midrst_busy",      alu.busy,      0);
    check("midrst_in_ready",  alu.in_ready,  1);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (alu.out_valid) seen = 1'b1; end
    check("midrst_no_result", seen, 0);

    // Random ops against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(0, 17));
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      do_op(op, a, b, r, z, lat);
      check($sformatf("rnd%0d_op%0d_rd", i, op), r,   model_rd(op, a, b));
      check($sformatf("rnd%0d_zero", i),         z,   (a == b));
      check($sformatf("rnd%0d_lat", i),          lat, model_lat(op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
